range_load_sequencer: RTL and testbench

// - Upstream feeder for the 6-bit range up/down counter. Drives its load, data and u_d inputs.
// - Accepts load requests over a valid/ready handshake and buffers them in a small FIFO.
// - Clamps each request into the counter's legal window [LO, HI-1], issues it as a 1-cycle load pulse,

---
 rtl/range_load_sequencer.sv | 161 ++++++++++++++++
 tb/tb_range_load_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/range_load_sequencer.sv
// Range load sequencer: buffers load requests in a FIFO, clamps them into [LO, HI-1] and issues
// spaced load pulses to the range counter. Define RANGE_LOAD_SEQ_DROP_OOR_EN to discard out-of-range entries.
module range_load_sequencer #(
    parameter int WIDTH       = 6,
    parameter int LO          = 10,
    parameter int HI          = 40,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_dir,
    output logic                     load,
    output logic [WIDTH-1:0]         data,
    output logic                     u_d,
    output logic                     busy,
    output logic                     clamp_flag,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [WIDTH-1:0] LO_V  = WIDTH'(LO);
    localparam logic [WIDTH-1:0] HI_V  = WIDTH'(HI);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(HI - 1);
    localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_e;

    typedef struct packed {
        logic             dir;
        logic [WIDTH-1:0] value;
        logic             oor;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    state_e           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             u_d_q, u_d_d;
    logic             clamp_q, clamp_d;

    logic   full, empty, push, pop, issue, drop;
    entry_t head, in_entry;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign push     = in_valid && !full;
    assign head     = mem_q[rd_ptr_q];
    assign in_entry = '{dir: in_dir, value: in_data, oor: (in_data < LO_V) || (in_data >= HI_V)};

    // NOTE: the FIFO storage has no reset; only the pointers and level need one to make it empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            hold_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            load_q   <= 1'b0;
            data_q   <= LO_V;
            u_d_q    <= 1'b1;
            clamp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            load_q   <= load_d;
            data_q   <= data_d;
            u_d_q    <= u_d_d;
            clamp_q  <= clamp_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE:  pop = !empty;
            S_ISSUE: begin
                state_d = S_HOLD;
                hold_d  = HOLD_LOAD;
            end
            S_HOLD: begin
                if (hold_q == '0) begin
                    pop     = !empty;
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef RANGE_LOAD_SEQ_DROP_OOR_EN
        drop = pop && head.oor;
`else
        drop = 1'b0;
`endif
        issue = pop && !drop;
        if (issue) begin
            state_d = S_ISSUE;
        end
    end

    always_comb begin
        load_d  = 1'b0;
        clamp_d = 1'b0;
        data_d  = data_q;
        u_d_d   = u_d_q;
        if (issue) begin
            load_d  = 1'b1;
            clamp_d = head.oor;
            u_d_d   = head.dir;
            if (head.value < LO_V) begin
                data_d = LO_V;
            end else if (head.value >= HI_V) begin
                data_d = MAX_V;
            end else begin
                data_d = head.value;
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    assign in_ready   = !full;
    assign load       = load_q;
    assign data       = data_q;
    assign u_d        = u_d_q;
    assign clamp_flag = clamp_q;
    assign fifo_level = level_q;
    assign busy       = (state_q != S_IDLE) || (level_q != '0);

endmodule

// File: tb/tb_range_load_sequencer.sv
// Directed bench for range_load_sequencer: reset, single request, back-to-back flow control,
// clamping (or dropping with RANGE_LOAD_SEQ_DROP_OOR_EN) and asynchronous reset mid-HOLD.
module tb_range_load_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_data;
    logic       in_dir;
    logic       load;
    logic [5:0] data;
    logic       u_d;
    logic       busy;
    logic       clamp_flag;
    logic [2:0] fifo_level;

    int n_checks = 0;
    int n_err    = 0;

    range_load_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_dir     (in_dir),
        .load       (load),
        .data       (data),
        .u_d        (u_d),
        .busy       (busy),
        .clamp_flag (clamp_flag),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [5:0] b2b_val [6] = '{6'd12, 6'd30, 6'd38, 6'd15, 6'd22, 6'd27};
    int         exp_lvl [12] = '{1, 1, 2, 3, 4, 4, 4, 4, 4, 4, 3, 4};
    int         rise_t [$];
    logic [5:0] rise_d [$];
    logic       rise_c [$];
    logic       prev_load;
    int         n_rise;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_dir   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        tick();

        // Reset then idle
        check("rst_load",  load, 0);
        check("rst_data",  data, 10);
        check("rst_ud",    u_d, 1);
        check("rst_ready", in_ready, 1);
        check("rst_level", fifo_level, 0);
        check("rst_busy",  busy, 0);
        check("rst_clamp", clamp_flag, 0);

        // Single request: 25, down
        in_valid = 1'b1; in_data = 6'd25; in_dir = 1'b0;
        tick();
        in_valid = 1'b0;
        check("single_level_k", fifo_level, 1);
        check("single_load_k",  load, 0);
        tick();
        check("single_load_k1",  load, 1);
        check("single_data_k1",  data, 25);
        check("single_ud_k1",    u_d, 0);
        check("single_clamp_k1", clamp_flag, 0);
        check("single_level_k1", fifo_level, 0);
        check("single_busy_k1",  busy, 1);
        tick();
        check("single_load_k2", load, 0);
        check("single_data_k2", data, 25);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("single_hold_load", load, 0);
            check("single_hold_busy", busy, 1);
            check("single_hold_ud",   u_d, 0);
        end
        tick();
        check("single_idle_busy", busy, 0);
        check("single_idle_ud",   u_d, 0);
        check("single_idle_data", data, 25);

        // Back-to-back: five pushes on consecutive edges, sixth held off by the full FIFO
        prev_load = load;
        in_dir = 1'b1;
        for (int j = 0; j < 57; j++) begin
            if (j <= 4) begin
                in_valid = 1'b1; in_data = b2b_val[j];
            end else if (j <= 11) begin
                in_valid = 1'b1; in_data = b2b_val[5];
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (load && !prev_load) begin
                rise_t.push_back(j);
                rise_d.push_back(data);
            end
            prev_load = load;
            if (j < 12) begin
                check("b2b_level", fifo_level, exp_lvl[j]);
                check("b2b_ready", in_ready, exp_lvl[j] != 4);
            end
        end
        in_valid = 1'b0;
        n_rise = rise_t.size();
        check("b2b_count", n_rise, 6);
        if (n_rise > 0) check("b2b_first_t", rise_t[0], 1);
        for (int k = 0; k < n_rise && k < 6; k++) begin
            check("b2b_data", rise_d[k], b2b_val[k]);
            if (k > 0) check("b2b_spacing", rise_t[k] - rise_t[k-1], 9);
        end
        check("b2b_end_busy",  busy, 0);
        check("b2b_end_level", fifo_level, 0);

        // Clamp: 3 then 63
        rise_t.delete();
        rise_d.delete();
        prev_load = load;
        for (int f = 0; f < 20; f++) begin
            if (f == 0) begin
                in_valid = 1'b1; in_data = 6'd3; in_dir = 1'b1;
            end else if (f == 1) begin
                in_valid = 1'b1; in_data = 6'd63; in_dir = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (load && !prev_load) begin
                rise_t.push_back(f);
                rise_d.push_back(data);
                rise_c.push_back(clamp_flag);
            end
            prev_load = load;
        end
        n_rise = rise_t.size();
`ifdef RANGE_LOAD_SEQ_DROP_OOR_EN
        check("drop_count", n_rise, 0);
`else
        check("clamp_count", n_rise, 2);
        if (n_rise >= 2) begin
            check("clamp_lo_t",     rise_t[0], 1);
            check("clamp_lo_data",  rise_d[0], 10);
            check("clamp_lo_flag",  rise_c[0], 1);
            check("clamp_hi_t",     rise_t[1], 10);
            check("clamp_hi_data",  rise_d[1], 39);
            check("clamp_hi_flag",  rise_c[1], 1);
        end
`endif
        check("clamp_end_level", fifo_level, 0);
        check("clamp_end_busy",  busy, 0);
        check("clamp_end_flag",  clamp_flag, 0);

        // Reset mid-HOLD with two entries queued
        in_dir = 1'b0;
        for (int g = 0; g < 3; g++) begin
            in_valid = 1'b1; in_data = 6'(20 + g);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("mid_level", fifo_level, 2);
        check("mid_ud",    u_d, 0);
        check("mid_busy",  busy, 1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_load",  load, 0);
        check("arst_data",  data, 10);
        check("arst_ud",    u_d, 1);
        check("arst_level", fifo_level, 0);
        check("arst_ready", in_ready, 1);
        check("arst_busy",  busy, 0);
        check("arst_clamp", clamp_flag, 0);
        #2;
        rst = 1'b0;
        n_rise = 0;
        for (int h = 0; h < 12; h++) begin
            tick();
            if (load) n_rise++;
        end
        check("post_rst_loads", n_rise, 0);
        check("post_rst_level", fifo_level, 0);
        in_valid = 1'b1; in_data = 6'd33; in_dir = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_push_load", load, 0);
        tick();
        check("post_push_load1", load, 1);
        check("post_push_data",  data, 33);
        check("post_push_ud",    u_d, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
